// File: rtl/tim_arb_wires.sv
// Shared types for the TIM two-master arbiter: request bundle and port select.
package tim_arb_wires;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } tim_arb_req_type;

    localparam tim_arb_req_type init_tim_arb_req = '0;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_sel_type;

endpackage

// File: rtl/tim_arb_buf.sv
// One-entry holder for a request that lost arbitration; clear wins over load.
module tim_arb_buf
    import tim_arb_wires::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  tim_arb_req_type req,
    output logic            occupied,
    output tim_arb_req_type req_out
);

    tim_arb_req_type held;

    always_ff @(posedge clock) begin
        if (!reset) begin
            held <= init_tim_arb_req;
        end else if (clear) begin
            held <= init_tim_arb_req;
        end else if (load) begin
            held <= req;
        end
    end

    assign occupied = held.valid;
    assign req_out  = held;

endmodule

// File: rtl/tim_arbiter.sv
// Merges fetch and load/store ports onto the single-ported TIM and steers
// each one-cycle-later response back to the port that issued the request.
module tim_arbiter
    import tim_arb_wires::*;
#(
    parameter logic fair = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        tim_valid,
    output logic        tim_instr,
    output logic [31:0] tim_addr,
    output logic [31:0] tim_wdata,
    output logic [3:0]  tim_wstrb,
    input  logic [31:0] tim_rdata,
    input  logic        tim_ready
);

    tim_arb_req_type live_i, live_d, pend_i, pend_d, cand_i, cand_d, gnt;
    logic            occ_i, occ_d, conflict, grant_i, grant_d;
    logic            owner_valid, owner_is_instr;
    port_sel_type    last_grant;

    always_comb begin
        live_i       = init_tim_arb_req;
        live_i.valid = imem_valid;
        live_i.instr = 1'b1;
        live_i.addr  = imem_addr;

        live_d       = init_tim_arb_req;
        live_d.valid = dmem_valid;
        live_d.addr  = dmem_addr;
        live_d.wdata = dmem_wdata;
        live_d.wstrb = dmem_wstrb;
    end

    // A held entry shadows any live valid on the same port.
    assign cand_i   = occ_i ? pend_i : live_i;
    assign cand_d   = occ_d ? pend_d : live_d;
    assign conflict = cand_i.valid & cand_d.valid;

    always_comb begin
        grant_d = cand_d.valid;
        if (conflict) begin
            grant_d = fair ? (last_grant == PORT_I) : 1'b1;
        end
        grant_i = cand_i.valid & ~grant_d;
    end

    always_comb begin
        gnt = init_tim_arb_req;
        if (grant_d) begin
            gnt = cand_d;
        end else if (grant_i) begin
            gnt = cand_i;
        end
    end

    assign tim_valid = gnt.valid;
    assign tim_instr = grant_i;
    assign tim_addr  = gnt.addr;
    assign tim_wdata = grant_i ? 32'd0 : gnt.wdata;
    assign tim_wstrb = grant_i ? 4'd0 : gnt.wstrb;

    tim_arb_buf u_buf_i (
        .clock    (clock),
        .reset    (reset),
        .load     (imem_valid & ~occ_i & ~grant_i),
        .clear    (occ_i & grant_i),
        .req      (live_i),
        .occupied (occ_i),
        .req_out  (pend_i)
    );

    tim_arb_buf u_buf_d (
        .clock    (clock),
        .reset    (reset),
        .load     (dmem_valid & ~occ_d & ~grant_d),
        .clear    (occ_d & grant_d),
        .req      (live_d),
        .occupied (occ_d),
        .req_out  (pend_d)
    );

    // Round-robin memory only advances on an actual conflict.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant <= PORT_I;
        end else if (conflict) begin
            last_grant <= grant_d ? PORT_D : PORT_I;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_valid    <= 1'b0;
            owner_is_instr <= 1'b0;
        end else begin
            owner_valid    <= tim_valid;
            owner_is_instr <= tim_instr;
        end
    end

    assign imem_ready = tim_ready & owner_valid & owner_is_instr;
    assign dmem_ready = tim_ready & owner_valid & ~owner_is_instr;
    assign imem_rdata = (owner_valid & owner_is_instr)  ? tim_rdata : 32'd0;
    assign dmem_rdata = (owner_valid & ~owner_is_instr) ? tim_rdata : 32'd0;

endmodule

// File: tb/tb_tim_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same stimulus and
// checks both against a per-cycle reference model of the arbitration rules.
module tb_tim_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_addr = '0;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] tim_rdata = '0;

    logic [31:0] imem_rdata_o[2];
    logic        imem_ready_o[2];
    logic [31:0] dmem_rdata_o[2];
    logic        dmem_ready_o[2];
    logic        tim_valid_o[2];
    logic        tim_instr_o[2];
    logic [31:0] tim_addr_o[2];
    logic [31:0] tim_wdata_o[2];
    logic [3:0]  tim_wstrb_o[2];
    logic        tim_ready_i[2] = '{1'b0, 1'b0};

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference state: index [instance][port], port 0 = imem, 1 = dmem.
    bit          p_v[2][2];
    logic [31:0] p_a[2][2];
    logic [31:0] p_w[2][2];
    logic [3:0]  p_s[2][2];
    bit          last_d[2];
    bit          resp_v[2];
    bit          resp_i[2];

    always #5 clock = ~clock;

    // TIM itself: answers every accepted request exactly one cycle later.
    always @(posedge clock) begin
        tim_ready_i[0] <= tim_valid_o[0];
        tim_ready_i[1] <= tim_valid_o[1];
    end

    tim_arbiter #(.fair(1'b1)) u_fair (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata_o[0]), .imem_ready(imem_ready_o[0]),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata_o[0]), .dmem_ready(dmem_ready_o[0]),
        .tim_valid(tim_valid_o[0]), .tim_instr(tim_instr_o[0]),
        .tim_addr(tim_addr_o[0]), .tim_wdata(tim_wdata_o[0]),
        .tim_wstrb(tim_wstrb_o[0]), .tim_rdata(tim_rdata),
        .tim_ready(tim_ready_i[0])
    );

    tim_arbiter #(.fair(1'b0)) u_prio (
        .clock(clock), .reset(reset),
        .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata_o[1]), .imem_ready(imem_ready_o[1]),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata_o[1]), .dmem_ready(dmem_ready_o[1]),
        .tim_valid(tim_valid_o[1]), .tim_instr(tim_instr_o[1]),
        .tim_addr(tim_addr_o[1]), .tim_wdata(tim_wdata_o[1]),
        .tim_wstrb(tim_wstrb_o[1]), .tim_rdata(tim_rdata),
        .tim_ready(tim_ready_i[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check both instances, advance the model.
    task automatic cycle(input bit rst, input bit iv, input logic [31:0] ia,
                         input bit dv, input logic [31:0] da, input logic [31:0] dw,
                         input logic [3:0] ds, input logic [31:0] rd);
        bit          cv[2];
        logic [31:0] ca[2];
        logic [31:0] cw[2];
        logic [3:0]  cs[2];
        bit          live[2];
        int          win;
        string       sfx;

        reset = rst; imem_valid = iv; imem_addr = ia;
        dmem_valid = dv; dmem_addr = da; dmem_wdata = dw; dmem_wstrb = ds;
        tim_rdata = rd;
        #4;
        live[0] = iv;
        live[1] = dv;
        for (int k = 0; k < 2; k++) begin
            sfx = (k == 0) ? "_fair" : "_prio";
            for (int p = 0; p < 2; p++) begin
                if (p_v[k][p]) begin
                    cv[p] = 1'b1; ca[p] = p_a[k][p]; cw[p] = p_w[k][p]; cs[p] = p_s[k][p];
                end else begin
                    cv[p] = live[p];
                    ca[p] = (p == 0) ? ia : da;
                    cw[p] = (p == 0) ? 32'd0 : dw;
                    cs[p] = (p == 0) ? 4'd0 : ds;
                end
            end
            if (cv[0] && cv[1])
                win = (k == 1) ? 1 : (last_d[k] ? 0 : 1);
            else if (cv[1])
                win = 1;
            else if (cv[0])
                win = 0;
            else
                win = -1;

            if (chk_en) begin
                check({"tim_valid", sfx}, 32'(tim_valid_o[k]), 32'(win >= 0));
                if (win >= 0) begin
                    check({"tim_instr", sfx}, 32'(tim_instr_o[k]), 32'(win == 0));
                    check({"tim_addr", sfx}, tim_addr_o[k], ca[win]);
                    check({"tim_wstrb", sfx}, 32'(tim_wstrb_o[k]), 32'(cs[win]));
                    if (win == 1)
                        check({"tim_wdata", sfx}, tim_wdata_o[k], cw[1]);
                end else begin
                    check({"idle_addr", sfx}, tim_addr_o[k], 32'd0);
                    check({"idle_wdata", sfx}, tim_wdata_o[k], 32'd0);
                    check({"idle_wstrb", sfx}, 32'(tim_wstrb_o[k]), 32'd0);
                end
                check({"imem_ready", sfx}, 32'(imem_ready_o[k]), 32'(resp_v[k] && resp_i[k]));
                check({"dmem_ready", sfx}, 32'(dmem_ready_o[k]), 32'(resp_v[k] && !resp_i[k]));
                check({"imem_rdata", sfx}, imem_rdata_o[k], (resp_v[k] && resp_i[k]) ? rd : 32'd0);
                check({"dmem_rdata", sfx}, dmem_rdata_o[k], (resp_v[k] && !resp_i[k]) ? rd : 32'd0);
            end

            if (!rst) begin
                p_v[k][0] = 1'b0; p_v[k][1] = 1'b0;
                last_d[k] = 1'b0; resp_v[k] = 1'b0; resp_i[k] = 1'b0;
            end else begin
                if (cv[0] && cv[1])
                    last_d[k] = (win == 1);
                resp_v[k] = (win >= 0);
                resp_i[k] = (win == 0);
                for (int p = 0; p < 2; p++) begin
                    if (win == p && p_v[k][p]) begin
                        p_v[k][p] = 1'b0;
                    end else if (win != p && live[p] && !p_v[k][p]) begin
                        p_v[k][p] = 1'b1;
                        p_a[k][p] = (p == 0) ? ia : da;
                        p_w[k][p] = (p == 0) ? 32'd0 : dw;
                        p_s[k][p] = (p == 0) ? 4'd0 : ds;
                    end
                end
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, $urandom);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            last_d[k] = 1'b0; resp_v[k] = 1'b0; resp_i[k] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                p_v[k][p] = 1'b0; p_a[k][p] = '0; p_w[k][p] = '0; p_s[k][p] = '0;
            end
        end

        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        chk_en = 1'b1;
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0);

        // Lone fetch, response data returned next cycle.
        cycle(1'b1, 1'b1, 32'h100, 1'b0, 32'd0, 32'd0, 4'd0, 32'h0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 32'hDEADBEEF);
        idle(2);

        // First conflict, then a second one.
        cycle(1'b1, 1'b1, 32'h10, 1'b1, 32'h20, 32'h11223344, 4'hF, $urandom);
        idle(3);
        cycle(1'b1, 1'b1, 32'h50, 1'b1, 32'h60, 32'h0, 4'h0, $urandom);
        idle(3);

        // dmem reissues on every ready while imem waits.
        cycle(1'b1, 1'b1, 32'h70, 1'b1, 32'h80, 32'hA5A5A5A5, 4'h3, $urandom);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h84, 32'h5A5A5A5A, 4'hC, $urandom);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h88, 32'h01020304, 4'h1, $urandom);
        idle(3);

        // Conflict followed by reset: pending entry and due response dropped.
        cycle(1'b1, 1'b1, 32'h200, 1'b1, 32'h204, 32'hCAFEF00D, 4'hF, $urandom);
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, $urandom);
        idle(3);

        // Duplicate dmem valid while its request is held.
        cycle(1'b1, 1'b1, 32'h300, 1'b1, 32'h304, 32'h0, 4'h0, $urandom);
        idle(3);
        cycle(1'b1, 1'b1, 32'h90, 1'b1, 32'h30, 32'h77665544, 4'h6, $urandom);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 32'h40, 32'h99999999, 4'h9, $urandom);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 9) < 4), $urandom,
                  ($urandom_range(0, 9) < 4), $urandom, $urandom,
                  4'($urandom_range(0, 15)), $urandom);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tim_arbiter.md
Name: tim_arbiter

Overview:
- Two-master front end for the single-ported tightly-integrated memory (TIM).
- Merges the fetch port (imem) and the load/store port (dmem) onto one TIM request port; TIM returns ready exactly one cycle after each accepted valid.
- Buffers the losing request for one or more cycles and arbitrates between ports.
- Routes each TIM response back to the port that issued it.

Parameters:
- fair, 1, 1 = round-robin between ports on conflict; 0 = fixed priority, dmem wins.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low reset
- imem_valid  in  1  fetch request, one-cycle pulse
- imem_addr  in  32  fetch byte address
- imem_rdata  out  32  fetch read data
- imem_ready  out  1  fetch response strobe
- dmem_valid  in  1  data request, one-cycle pulse
- dmem_addr  in  32  data byte address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte strobes; 0 = read
- dmem_rdata  out  32  data read data
- dmem_ready  out  1  data response strobe
- tim_valid  out  1  request to TIM
- tim_instr  out  1  1 = fetch, 0 = data
- tim_addr  out  32  address to TIM
- tim_wdata  out  32  write data to TIM
- tim_wstrb  out  4  strobes to TIM; 0 for fetch
- tim_rdata  in  32  TIM read data
- tim_ready  in  1  TIM response, one cycle after tim_valid

Behaviour:
- Protocol:
  - Each master holds at most one outstanding request and pulses valid for one cycle.
  - A new valid is legal in the same cycle as that master's ready.
  - A valid while the same port already holds an outstanding request is ignored; the held request is kept.
- Pending buffers: one entry per port (valid, addr, wdata, wstrb).
- Candidates each cycle: per port, the pending entry if occupied, else the live input request.
- Grant: one candidate per cycle, driven combinationally onto tim_* (zero added latency when uncontended).
  - Only one candidate: grant it.
  - Both candidates, fair=1: grant the port not granted last (last_grant register, reset value = imem, so dmem wins the first conflict).
  - Both candidates, fair=0: dmem wins.
  - A granted pending entry is cleared at the clock edge.
  - A losing live request is written into its pending buffer.
- Owner register:
  - owner_valid <= tim_valid; owner_is_instr <= tim_instr.
  - imem_ready = tim_ready & owner_valid & owner_is_instr; dmem_ready likewise with ~owner_is_instr.
  - rdata of the non-owning port is 0; owning port sees tim_rdata.
- Latency:
  - Uncontended: ready at t+1.
  - Loser of a conflict at t: granted t+1, ready t+2.
  - With fair=0, imem may wait indefinitely while dmem keeps issuing.
- tim_valid = 0 when no candidate; tim_addr, tim_wdata, tim_wstrb = 0 when idle; tim_wstrb = 0 on imem grant.
- Simultaneous grant and new request from the same port in one cycle: impossible under the protocol; the RTL still prioritises the pending entry.
- Reset (reset==0 at edge):
  - Pending buffers, owner_valid and last_grant are cleared.
  - Next cycle: all ready and rdata outputs are 0, tim_valid follows the live inputs only.
  - A response due from the pre-reset grant is suppressed.

Decomposition:
- Package tim_arb_wires holds:
  - tim_arb_req_type struct (valid, instr, addr, wdata, wstrb) and init_tim_arb_req.
  - Port-select enum (PORT_I, PORT_D).
- Sub-module tim_arb_buf: one-entry pending holder with inputs load, clear, req and outputs occupied, req_out; instantiated once per port.
- Top-level contents: grant logic, last_grant, owner register.

Test Plan:
1. imem_valid pulse addr 0x100 alone -> tim_valid same cycle, tim_instr=1, tim_addr=0x100; next cycle tim_rdata 0xDEADBEEF -> imem_ready=1, imem_rdata=0xDEADBEEF, dmem_ready=0, dmem_rdata=0.
2. Simultaneous imem 0x10 and dmem write 0x20 wdata 0x11223344 wstrb 0xF, fair=1 after reset -> dmem granted t, imem granted t+1 from pending, dmem_ready t+1, imem_ready t+2.
3. Second conflict after test 2, fair=1 -> imem wins (last_grant=dmem); fair=0 -> dmem wins both conflicts.
4. dmem issues back-to-back each cycle on its ready while imem is pending, fair=1 -> imem granted within one cycle; imem_ready by t+2.
5. Conflict at t, then reset low at t+1 -> pending imem dropped, no imem_ready or dmem_ready at t+2, tim_valid=0 with idle inputs.
6. Duplicate dmem_valid (addr 0x40) while dmem request 0x30 is pending -> only 0x30 reaches tim_addr; exactly one dmem_ready.
